simon_sequencer: RTL and testbench

- Game controller that consumes the free-running 1..4 random value and builds a Simon-style memory sequence, one step per round.
- Each round: captures one random value, plays the whole stored sequence on four LEDs, then checks the player's button presses against it.
- Sits downstream of the randomizer and upstream of the LED drivers and the score display.
- Button inputs arrive as debounced single-cycle pulses.

---
 rtl/simon_pkg.sv | 9 +
 rtl/simon_sequencer_timer.sv | 20 ++
 rtl/simon_sequencer.sv | 117 +++++++++++
 tb/tb_simon_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, LED mapping and constants for the Simon sequencer
package simon_pkg;
    typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_INPUT, WIN, LOSE} state_t;
    localparam logic [3:0] LED_ALL = 4'b1111;
    // out-of-range values fall back to the first LED
    function automatic logic [3:0] onehot(input logic [2:0] v);
        return (v >= 3'd1 && v <= 3'd4) ? 4'b0001 << (v - 3'd1) : 4'b0001;
    endfunction
endpackage

// File: rtl/simon_sequencer_timer.sv
// step_timer: loadable down-counter that stops at zero
//   clk, rst      : clock, sync active-high reset
//   load/load_val : load the counter with load_val
//   zero          : counter has reached zero
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon memory game controller, one new step per round
//   clk, rst   : clock, sync active-high reset
//   random     : free-running 1..4 value sampled once per round
//   start      : pulse that starts a new game from IDLE/WIN/LOSE
//   btn_pulse  : one-hot debounced button pulses
//   led        : LED drive; score: rounds completed
//   busy       : playback in progress; game_over/win: end states
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 25_000_000,
    parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       random,
    input  logic             start,
    input  logic [3:0]       btn_pulse,
    output logic [3:0]       led,
    output logic [LEN_W-1:0] score,
    output logic             busy,
    output logic             game_over,
    output logic             win
);
    localparam int TMAX = SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
    state_t state, state_n;
    logic [LEN_W-1:0] len, len_n, idx, idx_n, score_n;
    logic [2:0] seq [MAX_LEN];
    logic wr, tload, tzero, last;
    logic [TW-1:0] tval;
    logic [3:0] cur;
    assign cur = onehot(seq[idx[IW-1:0]]);
    assign last = idx == len - 1'b1;
    step_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .load(tload), .load_val(tval), .zero(tzero)
    );
    always_comb begin
        state_n = state;
        len_n = len;
        idx_n = idx;
        score_n = score;
        wr = 1'b0;
        tload = 1'b0;
        tval = SHOW_LD;
        led = '0;
        busy = 1'b0;
        game_over = state == LOSE;
        win = state == WIN;
        case (state)
            IDLE, WIN, LOSE: begin
                led = state == WIN ? LED_ALL : '0;
                if (start) begin
                    state_n = ADD;
                    len_n = '0;
                    idx_n = '0;
                    score_n = '0;
                end
            end
            ADD: begin
                wr = 1'b1;
                len_n = len + 1'b1;
                idx_n = '0;
                tload = 1'b1;
                state_n = SHOW_ON;
            end
            SHOW_ON: begin
                led = cur;
                busy = 1'b1;
                if (tzero) begin
                    tload = 1'b1;
                    tval = GAP_LD;
                    state_n = SHOW_OFF;
                end
            end
            SHOW_OFF: begin
                busy = 1'b1;
                if (tzero) begin
                    idx_n = last ? '0 : idx + 1'b1;
                    tload = !last;
                    state_n = last ? WAIT_INPUT : SHOW_ON;
                end
            end
            WAIT_INPUT: begin
                // a multi-bit press can never equal a one-hot code, so it loses
                if (btn_pulse != '0) begin
                    if (btn_pulse != cur) state_n = LOSE;
                    else if (!last) idx_n = idx + 1'b1;
                    else begin
                        score_n = len;
                        state_n = len == LEN_W'(MAX_LEN) ? WIN : ADD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            len <= '0;
            idx <= '0;
            score <= '0;
        end else begin
            state <= state_n;
            len <= len_n;
            idx <= idx_n;
            score <= score_n;
        end
    always_ff @(posedge clk)
        if (wr) seq[len[IW-1:0]] <= random;
endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer: randomized game play checked against an output-segment scoreboard
module tb_simon_sequencer;
    localparam int MAX_LEN = 3, SHOW = 4, GAP = 2, LW = 2, VW = 7 + LW;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] random = 3'd0;
    logic [3:0] btn = 4'd0;
    logic [3:0] led;
    logic [LW-1:0] score;
    logic busy, game_over, win;
    int cyc = 0, n_chk = 0, n_fail = 0;
    bit mon_en = 1'b0;
    typedef struct { logic [VW-1:0] v; int start; int dur; } seg_t;
    seg_t expq[$];
    logic [VW-1:0] last_vec;
    logic [3:0] lut [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};

    simon_sequencer #(.MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .random(random), .start(start), .btn_pulse(btn),
        .led(led), .score(score), .busy(busy), .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] mk(input logic [3:0] l, input logic b, input logic g,
                                         input logic w, input logic [LW-1:0] s);
        return {l, b, g, w, s};
    endfunction

    // expected output segment: value, first cycle (-1 any), length (0 any); equal neighbours merge
    function automatic void push(input logic [VW-1:0] v, input int st, input int d);
        seg_t s;
        if (expq.size() > 0 && v === last_vec) begin
            s = expq.pop_back();
            s.dur = 0;
            expq.push_back(s);
        end else begin
            s.v = v;
            s.start = st;
            s.dur = d;
            expq.push_back(s);
        end
        last_vec = v;
    endfunction

    // playback of the whole sequence, then the wait for input; returns first wait cycle
    function automatic int push_play(input int sq[$], input int t0, input logic [LW-1:0] sc);
        int t = t0;
        foreach (sq[i]) begin
            push(mk(lut[sq[i]], 1'b1, 1'b0, 1'b0, sc), t, SHOW);
            t += SHOW;
            push(mk(4'b0, 1'b1, 1'b0, 1'b0, sc), t, GAP);
            t += GAP;
        end
        push(mk(4'b0, 1'b0, 1'b0, 1'b0, sc), t, 0);
        return t;
    endfunction

    task automatic check_seg(input logic [VW-1:0] v, input int st, input int d);
        seg_t e;
        n_chk++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL extra_segment: got outputs %h from cycle %0d, required no change", v, st);
            return;
        end
        e = expq.pop_front();
        if (v !== e.v) begin
            n_fail++;
            $display("FAIL seg_outputs: got %h required %h (segment from cycle %0d)", v, e.v, st);
        end
        if (e.start >= 0) begin
            n_chk++;
            if (st != e.start) begin
                n_fail++;
                $display("FAIL seg_start: outputs %h began at cycle %0d, required %0d", v, st, e.start);
            end
        end
        if (e.dur > 0) begin
            n_chk++;
            if (d != e.dur) begin
                n_fail++;
                $display("FAIL seg_length: outputs %h lasted %0d cycles, required %0d", v, d, e.dur);
            end
        end
    endtask

    initial begin
        logic [VW-1:0] cur_v, o;
        int st;
        wait (mon_en);
        @(posedge clk);
        #1;
        cur_v = {led, busy, game_over, win, score};
        st = cyc;
        forever begin
            @(posedge clk);
            #1;
            o = {led, busy, game_over, win, score};
            if (o !== cur_v) begin
                check_seg(cur_v, st, cyc - st);
                cur_v = o;
                st = cyc;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // fr: round with a bad press (0 none); fk: kind of bad press; rr: round aborted by reset
    task automatic play_game(input int v0, input int v1, input int v2, input int fr,
                             input int fk, input bit noise, input int rr);
        int vals[3];
        int sq[$];
        int t, p, fi;
        logic [LW-1:0] sc;
        logic [3:0] good, bad, rot;
        seg_t keep;
        vals = '{v0, v1, v2};
        foreach (vals[i]) if (vals[i] < 0) vals[i] = $urandom_range(0, 7);
        @(negedge clk);
        start = 1'b1;
        random = 3'(vals[0]);
        p = cyc;
        sc = '0;
        push(mk(4'b0, 1'b0, 1'b0, 1'b0, sc), p + 1, 1);
        sq.push_back(vals[0]);
        t = push_play(sq, p + 2, sc);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        random = 3'($urandom);
        for (int r = 1; r <= MAX_LEN; r++) begin
            if (r == rr) begin
                wait_until(int'($urandom_range(cyc, t - 1)));
                rst = 1'b1;
                if (expq.size() > 0) begin
                    keep = expq.pop_front();
                    keep.dur = cyc + 1 - keep.start;
                    expq.delete();
                    expq.push_back(keep);
                    last_vec = keep.v;
                end
                push(mk(4'b0, 1'b0, 1'b0, 1'b0, '0), cyc + 1, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (noise) begin
                wait_until(int'($urandom_range(cyc, t - 1)));
                btn = 4'($urandom_range(1, 15));
                start = 1'b1;
                @(negedge clk);
                btn = '0;
                start = 1'b0;
            end
            wait_until(t);
            fi = (r == fr) ? int'($urandom_range(0, r - 1)) : -1;
            for (int i = 0; i < r; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                p = cyc;
                good = lut[sq[i]];
                if (i == fi) begin
                    rot = {good[2:0], good[3]};
                    bad = (fk == 0) ? rot : (fk == 1) ? 4'b0011 :
                          (fk == 2 && good != 4'b0001) ? 4'b0001 : (good | rot);
                    btn = bad;
                    push(mk(4'b0, 1'b0, 1'b1, 1'b0, sc), p + 1, 0);
                    @(negedge clk);
                    btn = '0;
                    return;
                end
                btn = good;
                if (i == r - 1) begin
                    sc = LW'(r);
                    if (r == MAX_LEN) push(mk(4'b1111, 1'b0, 1'b0, 1'b1, sc), p + 1, 0);
                    else begin
                        random = 3'(vals[r]);
                        push(mk(4'b0, 1'b0, 1'b0, 1'b0, sc), p + 1, 1);
                        sq.push_back(vals[r]);
                        t = push_play(sq, p + 2, sc);
                    end
                end
                @(negedge clk);
                btn = '0;
            end
            if (r < MAX_LEN) begin
                @(negedge clk);
                random = 3'($urandom);
            end
        end
    endtask

    initial begin
        int fr, rr;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(mk(4'b0, 1'b0, 1'b0, 1'b0, '0), -1, 0);
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        play_game(3, 1, 4, 0, 0, 1'b0, 0);
        play_game(2, -1, -1, 1, 2, 1'b0, 0);
        play_game(-1, -1, -1, 2, 1, 1'b1, 0);
        play_game(-1, -1, -1, 0, 0, 1'b1, 2);
        repeat (25) begin
            fr = $urandom_range(0, 3);
            rr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            play_game(-1, -1, -1, rr != 0 ? 0 : fr, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push(mk(4'b0, 1'b0, 1'b0, 1'b0, '0), cyc + 1, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (expq.size() != 1) begin
            n_fail++;
            $display("FAIL pending_segments: got %0d left in queue, required 1", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
